// File: rtl/operand_fetch.sv
// Register-operand fetch: accepts rs1/rs2, reads the RF, returns bypassed operands; accept->valid is 1 cycle.
// Backpressure: op_ready_n high holds operands (kept coherent by writeback snoop) and blocks new requests.
module operand_fetch (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_n,
    output logic        req_ready_n,
    input  logic [3:0]  rs1_addr,
    input  logic [3:0]  rs2_addr,
    input  logic        wb_en_n,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        rf_write_en_n,
    output logic [3:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        rf_read_en_n,
    output logic [3:0]  rf_read_addr_a,
    output logic [3:0]  rf_read_addr_b,
    input  logic [31:0] rf_read_data_a,
    input  logic [31:0] rf_read_data_b,
    output logic        op_valid_n,
    input  logic        op_ready_n,
    output logic [31:0] op_a,
    output logic [31:0] op_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic        byp_vld;
        logic [31:0] byp_dat;
        logic [31:0] op_dat;
    } opnd_t;

    state_t state_q, state_d;
    opnd_t  opa_q, opa_d;
    opnd_t  opb_q, opb_d;

    logic wb_vld;
    logic accept;
    logic handoff;

    // Writebacks to r0 are forwarded to the RF but never snooped.
    assign wb_vld  = !wb_en_n && (wb_addr != 4'd0);
    assign accept  = (state_q == ST_IDLE) && !req_valid_n;
    assign handoff = (state_q == ST_VALID) && !op_ready_n;

    // The RF returns the pre-write value for a same-edge write, so the accept-edge writeback is captured here.
    function automatic opnd_t opnd_next(
        input opnd_t       cur,
        input state_t      st,
        input logic        acc,
        input logic        hand,
        input logic [3:0]  req_addr,
        input logic        wbv,
        input logic [3:0]  wba,
        input logic [31:0] wbd,
        input logic [31:0] rf_dat
    );
        opnd_t nxt;
        nxt = cur;
        case (st)
            ST_IDLE: begin
                if (acc) begin
                    nxt.addr    = req_addr;
                    nxt.byp_vld = wbv && (wba == req_addr);
                    if (wbv && (wba == req_addr)) begin
                        nxt.byp_dat = wbd;
                    end
                end
            end
            ST_READ: begin
                if (cur.addr == 4'd0) begin
                    nxt.op_dat = 32'd0;
                end else if (wbv && (wba == cur.addr)) begin
                    nxt.op_dat = wbd;
                end else if (cur.byp_vld) begin
                    nxt.op_dat = cur.byp_dat;
                end else begin
                    nxt.op_dat = rf_dat;
                end
                nxt.byp_vld = 1'b0;
            end
            ST_VALID: begin
                // A writeback on the handoff edge belongs to the next consumer, not this one.
                if (!hand && wbv && (wba == cur.addr)) begin
                    nxt.op_dat = wbd;
                end
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)  state_d = ST_READ;
            ST_READ:  state_d = ST_VALID;
            ST_VALID: if (handoff) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        opa_d = opnd_next(opa_q, state_q, accept, handoff, rs1_addr,
                          wb_vld, wb_addr, wb_data, rf_read_data_a);
        opb_d = opnd_next(opb_q, state_q, accept, handoff, rs2_addr,
                          wb_vld, wb_addr, wb_data, rf_read_data_b);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    assign req_ready_n    = !(reset_n && (state_q == ST_IDLE));
    assign rf_read_en_n   = (reset_n && (state_q == ST_IDLE)) ? req_valid_n : 1'b1;
    assign rf_read_addr_a = (state_q == ST_IDLE) ? rs1_addr : opa_q.addr;
    assign rf_read_addr_b = (state_q == ST_IDLE) ? rs2_addr : opb_q.addr;

    assign rf_write_en_n  = wb_en_n | ~reset_n;
    assign rf_write_addr  = wb_addr;
    assign rf_write_data  = wb_data;

    assign op_valid_n     = (state_q != ST_VALID);
    assign op_a           = opa_q.op_dat;
    assign op_b           = opb_q.op_dat;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: external RF model, architectural register model, request scoreboard.
module tb_operand_fetch;

    logic        clk;
    logic        reset_n;
    logic        req_valid_n;
    logic        req_ready_n;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic        wb_en_n;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_write_en_n;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_read_en_n;
    logic [3:0]  rf_read_addr_a;
    logic [3:0]  rf_read_addr_b;
    logic [31:0] rf_read_data_a = '0;
    logic [31:0] rf_read_data_b = '0;
    logic        op_valid_n;
    logic        op_ready_n;
    logic [31:0] op_a;
    logic [31:0] op_b;

    int total = 0;
    int bad   = 0;

    operand_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid_n    (req_valid_n),
        .req_ready_n    (req_ready_n),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .wb_en_n        (wb_en_n),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .rf_write_en_n  (rf_write_en_n),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_read_en_n   (rf_read_en_n),
        .rf_read_addr_a (rf_read_addr_a),
        .rf_read_addr_b (rf_read_addr_b),
        .rf_read_data_a (rf_read_data_a),
        .rf_read_data_b (rf_read_data_b),
        .op_valid_n     (op_valid_n),
        .op_ready_n     (op_ready_n),
        .op_a           (op_a),
        .op_b           (op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read, returns the pre-write value on a same-edge write.
    logic [31:0] mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (!rf_write_en_n && rf_write_addr != 4'd0) mem[rf_write_addr] <= rf_write_data;
        if (!rf_read_en_n) begin
            rf_read_data_a <= (rf_read_addr_a == 4'd0) ? 32'd0 : mem[rf_read_addr_a];
            rf_read_data_b <= (rf_read_addr_b == 4'd0) ? 32'd0 : mem[rf_read_addr_b];
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: architectural register values, a queue of accepted requests,
    // and whether the oldest request has had its read cycle yet.
    logic [31:0] arch [16];
    logic [7:0]  req_q [$];
    bit          busy, loaded;
    logic [31:0] held_a, held_b;

    function automatic logic [31:0] rv(input logic [3:0] a);
        return (a == 4'd0) ? 32'd0 : arch[a];
    endfunction

    initial begin
        bit          do_acc, do_hand;
        logic [7:0]  ent;
        logic [3:0]  c1, c2;
        for (int i = 0; i < 16; i++) arch[i] = '0;
        busy = 0; loaded = 0; held_a = '0; held_b = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_req_ready_n", req_ready_n, 1);
                chk("rst_op_valid_n", op_valid_n, 1);
                chk("rst_op_a", op_a, 0);
                chk("rst_op_b", op_b, 0);
                chk("rst_rf_read_en_n", rf_read_en_n, 1);
                chk("rst_rf_write_en_n", rf_write_en_n, 1);
                req_q.delete();
                busy = 0; loaded = 0; held_a = '0; held_b = '0;
            end else begin
                c1 = busy ? req_q[0][7:4] : rs1_addr;
                c2 = busy ? req_q[0][3:0] : rs2_addr;
                chk("req_ready_n", req_ready_n, busy);
                chk("op_valid_n", op_valid_n, !(busy && loaded));
                chk("rf_read_en_n", rf_read_en_n, busy ? 1'b1 : req_valid_n);
                chk("rf_read_addr_a", rf_read_addr_a, c1);
                chk("rf_read_addr_b", rf_read_addr_b, c2);
                chk("rf_write_en_n", rf_write_en_n, wb_en_n);
                chk("rf_write_addr", rf_write_addr, wb_addr);
                chk("rf_write_data", rf_write_data, wb_data);
                if (busy && loaded) begin
                    chk("op_a_live", op_a, rv(c1));
                    chk("op_b_live", op_b, rv(c2));
                end else begin
                    chk("op_a_hold", op_a, held_a);
                    chk("op_b_hold", op_b, held_b);
                end
                do_hand = busy && loaded && !op_ready_n;
                do_acc  = !busy && !req_valid_n;
                if (do_hand) begin
                    ent = req_q.pop_front();
                    held_a = rv(ent[7:4]);
                    held_b = rv(ent[3:0]);
                    chk("handoff_a", op_a, held_a);
                    chk("handoff_b", op_b, held_b);
                    busy = 0; loaded = 0;
                end else if (busy) begin
                    loaded = 1;
                end
                if (do_acc) begin
                    req_q.push_back({rs1_addr, rs2_addr});
                    busy = 1; loaded = 0;
                end
                if (!wb_en_n && wb_addr != 4'd0) arch[wb_addr] = wb_data;
            end
        end
    end

    task automatic drive(input logic rv_n, input logic [3:0] a1, input logic [3:0] a2,
                         input logic we_n, input logic [3:0] wa, input logic [31:0] wd,
                         input logic ordy_n);
        @(posedge clk);
        #1;
        req_valid_n = rv_n; rs1_addr = a1; rs2_addr = a2;
        wb_en_n = we_n; wb_addr = wa; wb_data = wd; op_ready_n = ordy_n;
    endtask

    task automatic idle(input logic ordy_n);
        drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 32'd0, ordy_n);
    endtask

    initial begin
        reset_n = 1'b0; req_valid_n = 1'b1; rs1_addr = '0; rs2_addr = '0;
        wb_en_n = 1'b1; wb_addr = '0; wb_data = '0; op_ready_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready_n", req_ready_n, 0);

        // Plain read of a previously written register.
        drive(1, 0, 0, 0, 5, 32'h12345678, 0);
        drive(0, 5, 0, 1, 0, 0, 0);
        @(negedge clk); chk("s1_read_en_at_accept", rf_read_en_n, 0);
        idle(0);
        @(negedge clk); chk("s1_read_en_after", rf_read_en_n, 1);
        idle(0);
        @(negedge clk);
        chk("s1_valid", op_valid_n, 0);
        chk("s1_op_a", op_a, 32'h12345678);
        chk("s1_op_b", op_b, 0);
        idle(0);
        @(negedge clk); chk("s1_handed_off", op_valid_n, 1);

        // Writeback on the accept edge.
        drive(1, 0, 0, 0, 3, 32'h1, 0);
        drive(0, 3, 0, 0, 3, 32'hDEADBEEF, 0);
        idle(0); idle(0);
        @(negedge clk); chk("s2_same_edge_bypass", op_a, 32'hDEADBEEF);

        // Snoop during READ and during a stall.
        idle(0);
        drive(0, 7, 7, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 7, 32'hA, 1);
        drive(1, 0, 0, 0, 7, 32'hB, 1);
        @(negedge clk); chk("s3_e1_a", op_a, 32'hA); chk("s3_e1_b", op_b, 32'hA);
        idle(1);
        @(negedge clk); chk("s3_e2_a", op_a, 32'hB); chk("s3_e2_b", op_b, 32'hB);
        idle(0); idle(0);
        @(negedge clk); chk("s3_done", op_valid_n, 1); chk("s3_held", op_a, 32'hB);

        // r0 writeback passes through but never reaches an operand.
        drive(0, 0, 0, 0, 0, 32'hFFFFFFFF, 0);
        @(negedge clk); chk("s4_r0_write_passthru", rf_write_en_n, 0);
        idle(0); idle(0);
        @(negedge clk); chk("s4_r0_op_a", op_a, 0);

        // Writeback on the handoff edge.
        idle(0);
        drive(1, 0, 0, 0, 2, 32'h44, 0);
        drive(0, 2, 0, 1, 0, 0, 0);
        idle(0);
        drive(1, 0, 0, 0, 2, 32'h55, 0);
        @(negedge clk); chk("s5_consumer_sees_old", op_a, 32'h44);
        idle(0);
        drive(0, 2, 0, 1, 0, 0, 0);
        idle(0); idle(0);
        @(negedge clk); chk("s5_next_sees_new", op_a, 32'h55);
        idle(0);

        // Reset while holding valid operands.
        drive(0, 4, 4, 1, 0, 0, 1);
        idle(1); idle(1);
        @(negedge clk); chk("s6_valid_before_rst", op_valid_n, 0);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("s6_rst_op_valid_n", op_valid_n, 1);
        chk("s6_rst_op_a", op_a, 0);
        chk("s6_rst_op_b", op_b, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk); chk("s6_ready_after_rst", req_ready_n, 0);
        drive(0, 5, 3, 1, 0, 0, 0);
        idle(0); idle(0);
        @(negedge clk);
        chk("s6_new_req_a", op_a, 32'h12345678);
        chk("s6_new_req_b", op_b, 32'hDEADBEEF);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 3));
            reset_n = ($urandom_range(0, 99) != 0);
        end
        reset_n = 1'b1;
        repeat (6) idle(0);
        @(negedge clk);
        chk("drained", req_ready_n, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
